decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode stage for the MIPS-subset CPU, sitting between instruction fetch and execute. It accepts one 32-bit instruction plus its PC per valid/ready handshake and splits it into R, I and J fields. It resolves the destination register, extends the immediate, computes the jump target and generates the full control word. Results appear one cycle later in an output register that holds under back-pressure and clears on flush.

## Interface
- `WIDTH`, 32: datapath width of PC, immediate and jump target (must be ≥ 32).
- `REG_W`, 5: register-address width; fields occupy the low `REG_W` bits of the 5-bit instruction fields.
- `clk`  in  1  rising-edge clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  instruction/PC valid.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `pc`  in  WIDTH  address of `instr`.
- `flush`  in  1  squash stage contents (branch/jump redirect).
- `out_valid`  out  1  decoded word valid.
- `out_ready`  in  1  execute accepts.
- `rs`, `rt`, `wr_addr`  out  REG_W each  source registers and resolved destination.
- `shamt`  out  5  shift amount, `instr[10:6]`.
- `imm_ext`  out  WIDTH  extended `instr[15:0]`.
- `jump_target`  out  WIDTH  `{pc_plus4[WIDTH-1:28], instr[25:0], 2'b00}`.
- `pc_plus4`  out  WIDTH  registered `pc + 4`, modulo 2^WIDTH.
- `alu_src`, `jump`, `jump_link`, `jump_reg`, `branch_eq`, `branch_ne`, `mem_write`, `mem_to_reg`, `reg_write`  out  1 each  control.
- `alu_control`  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT.
- `illegal`  out  1  unsupported opcode/funct.

## Operation
- Decoding per op (`instr[31:26]`):
  - 0x00 R-type, keyed on funct (`instr[5:0]`):
    - 0x20 add: `reg_write=1`, `alu_control=ADD`, `wr_addr=rd`.
    - 0x22 sub: `reg_write=1`, `alu_control=SUB`, `wr_addr=rd`.
    - 0x2A slt: `reg_write=1`, `alu_control=SLT`, `wr_addr=rd`.
    - 0x08 jr: `jump_reg=1`, `reg_write=0`.
  - 0x08 addi: `alu_src=1`, ADD, `reg_write=1`, `wr_addr=rt`; immediate sign-extended.
  - 0x0E xori: `alu_src=1`, XOR, `reg_write=1`, `wr_addr=rt`; immediate zero-extended.
  - 0x23 lw: `alu_src=1`, ADD, `mem_to_reg=1`, `reg_write=1`, `wr_addr=rt`.
  - 0x2B sw: `alu_src=1`, ADD, `mem_write=1`.
  - 0x04 beq: SUB, `branch_eq=1`. 0x05 bne: SUB, `branch_ne=1`.
  - 0x02 j: `jump=1`. 0x03 jal: `jump=1`, `jump_link=1`, `reg_write=1`, `wr_addr=31`.
- Immediate extension: sign extension for every op except xori.
- Any other op, or an unlisted funct under op 0: `illegal=1` and every control output 0. The word is still delivered with `out_valid=1`.
- Control bits not listed for an op are 0.
- Handshake: `in_ready = !out_valid || out_ready`. A transfer occurs when `in_valid && in_ready`.
- Output register: loads on transfer and holds all outputs stable while `out_valid && !out_ready`.
- `out_valid` next state:
  - reset or flush: 0.
  - else transfer: 1.
  - else `out_ready`: 0.
  - else unchanged.
- Flush priority: flush overrides a simultaneous transfer. The incoming instruction is dropped and `out_valid` is 0 next cycle. `in_ready` still follows the formula during flush.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput is 1 per cycle while `out_ready=1`.
- Reset values: `out_valid=0`; all data and control outputs 0; `in_ready=1` (combinational from `out_valid`).
- Reset mid-stall discards the held word. Flush and reset take effect at the same edge.
- `in_ready` is combinational from `out_ready`. No combinational path from `instr` or `pc` to any output.
- `pc_plus4` wraps: for `WIDTH=32`, pc 0xFFFFFFFC gives 0x00000000.

## Test plan
- Reset then addi: `instr=0x2129FFFF` (addi $9,$9,-1). Next cycle: `out_valid=1`, `imm_ext=0xFFFFFFFF`, `wr_addr=9`, `alu_src=1`, `reg_write=1`, `alu_control=0`.
- Back-pressure: issue lw `0x8C880004` then sw `0xAC880004` with `out_ready=0` for 3 cycles. lw outputs are held, `in_ready=0`, sw is not lost; sw appears the cycle after `out_ready=1` with `mem_write=1`, `imm_ext=4`.
- jal at `pc=0x00400000`, `instr=0x0C100010`: `jump_target=0x00400040`, `wr_addr=31`, `jump_link=1`, `pc_plus4=0x00400004`.
- Flush with simultaneous `in_valid`: `out_valid=0` next cycle. The next accepted instruction decodes normally.
- Illegal: `instr=0xFC000000` → `illegal=1`, all controls 0, `out_valid=1`. R-type funct 0x3F → `illegal=1`.
- Streaming xori/slt/bne/jr with `out_ready=1`: one output per cycle. xori `0x3929FFFF` → `imm_ext=0x0000FFFF`, `alu_control=2`. slt → 3. bne → `branch_ne=1`, 1. jr → `jump_reg=1`.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and decoded-word bundle between fetch, the decode stage and execute.
// The stage itself uses the slave modport; the surrounding pipeline drives the master side.
interface decode_stage_if #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wr_addr;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc_plus4;
    logic             alu_src;
    logic             jump;
    logic             jump_link;
    logic             jump_reg;
    logic             branch_eq;
    logic             branch_ne;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [2:0]       alu_control;
    logic             illegal;

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, rs, rt, wr_addr, shamt, imm_ext, jump_target, pc_plus4,
               alu_src, jump, jump_link, jump_reg, branch_eq, branch_ne, mem_write,
               mem_to_reg, reg_write, alu_control, illegal
    );

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, rs, rt, wr_addr, shamt, imm_ext, jump_target, pc_plus4,
               alu_src, jump, jump_link, jump_reg, branch_eq, branch_ne, mem_write,
               mem_to_reg, reg_write, alu_control, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset instruction decode stage: combinational field/control decode feeding a
// single output register with valid/ready back-pressure and flush.
module decode_stage #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    jump;
        logic    jump_link;
        logic    jump_reg;
        logic    branch_eq;
        logic    branch_ne;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        alu_op_e alu_control;
        logic    illegal;
    } ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] wr_addr;
        logic [4:0]       shamt;
        logic [WIDTH-1:0] imm_ext;
        logic [WIDTH-1:0] jump_target;
        logic [WIDTH-1:0] pc_plus4;
        ctrl_t            ctrl;
    } word_t;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs_f;
    logic [REG_W-1:0] rt_f;
    logic [REG_W-1:0] rd_f;
    logic [WIDTH-1:0] pc4_d;
    ctrl_t            ctrl_d;
    logic [REG_W-1:0] dest_d;
    logic             sign_ext;
    word_t            word_d;
    word_t            word_q;
    logic             valid_q;
    logic             transfer;

    assign op    = bus.instr[31:26];
    assign funct = bus.instr[5:0];
    assign rs_f  = bus.instr[21 +: REG_W];
    assign rt_f  = bus.instr[16 +: REG_W];
    assign rd_f  = bus.instr[11 +: REG_W];
    assign pc4_d = bus.pc + WIDTH'(4);

    // Destination is forced to 0 whenever the instruction does not write a register.
    always_comb begin
        ctrl_d   = '0;
        dest_d   = '0;
        sign_ext = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_ADD;
                        dest_d             = rd_f;
                    end
                    FN_SUB: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_SUB;
                        dest_d             = rd_f;
                    end
                    FN_SLT: begin
                        ctrl_d.reg_write   = 1'b1;
                        ctrl_d.alu_control = ALU_SLT;
                        dest_d             = rd_f;
                    end
                    FN_JR:   ctrl_d.jump_reg = 1'b1;
                    default: ctrl_d.illegal  = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.reg_write   = 1'b1;
                dest_d             = rt_f;
            end
            OP_XORI: begin
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_XOR;
                ctrl_d.reg_write   = 1'b1;
                dest_d             = rt_f;
                sign_ext           = 1'b0;
            end
            OP_LW: begin
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.mem_to_reg  = 1'b1;
                ctrl_d.reg_write   = 1'b1;
                dest_d             = rt_f;
            end
            OP_SW: begin
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.mem_write   = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.alu_control = ALU_SUB;
                ctrl_d.branch_eq   = 1'b1;
            end
            OP_BNE: begin
                ctrl_d.alu_control = ALU_SUB;
                ctrl_d.branch_ne   = 1'b1;
            end
            OP_J: ctrl_d.jump = 1'b1;
            OP_JAL: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.jump_link = 1'b1;
                ctrl_d.reg_write = 1'b1;
                dest_d           = '1;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    always_comb begin
        word_d.rs          = rs_f;
        word_d.rt          = rt_f;
        word_d.wr_addr     = dest_d;
        word_d.shamt       = bus.instr[10:6];
        word_d.imm_ext     = sign_ext ? {{(WIDTH-16){bus.instr[15]}}, bus.instr[15:0]}
                                      : {{(WIDTH-16){1'b0}}, bus.instr[15:0]};
        word_d.jump_target = {pc4_d[WIDTH-1:28], bus.instr[25:0], 2'b00};
        word_d.pc_plus4    = pc4_d;
        word_d.ctrl        = ctrl_d;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign transfer     = bus.in_valid && bus.in_ready;

    // Flush shares reset's priority so a redirect always drops the incoming word.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (transfer) begin
            valid_q <= 1'b1;
            word_q  <= word_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.rs          = word_q.rs;
    assign bus.rt          = word_q.rt;
    assign bus.wr_addr     = word_q.wr_addr;
    assign bus.shamt       = word_q.shamt;
    assign bus.imm_ext     = word_q.imm_ext;
    assign bus.jump_target = word_q.jump_target;
    assign bus.pc_plus4    = word_q.pc_plus4;
    assign bus.alu_src     = word_q.ctrl.alu_src;
    assign bus.jump        = word_q.ctrl.jump;
    assign bus.jump_link   = word_q.ctrl.jump_link;
    assign bus.jump_reg    = word_q.ctrl.jump_reg;
    assign bus.branch_eq   = word_q.ctrl.branch_eq;
    assign bus.branch_ne   = word_q.ctrl.branch_ne;
    assign bus.mem_write   = word_q.ctrl.mem_write;
    assign bus.mem_to_reg  = word_q.ctrl.mem_to_reg;
    assign bus.reg_write   = word_q.ctrl.reg_write;
    assign bus.alu_control = word_q.ctrl.alu_control;
    assign bus.illegal     = word_q.ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then randomized traffic, checked
// against a mnemonic-level reference model of the stage's output register.
module tb_decode_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    decode_stage_if #(.WIDTH(32), .REG_W(5)) bus ();

    decode_stage #(.WIDTH(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_addr;
        logic [4:0]  shamt;
        logic [31:0] imm_ext;
        logic [31:0] jump_target;
        logic [31:0] pc_plus4;
        logic        alu_src;
        logic        jump;
        logic        jump_link;
        logic        jump_reg;
        logic        branch_eq;
        logic        branch_ne;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [2:0]  alu_control;
        logic        illegal;
    } exp_t;

    exp_t m_word;
    logic m_valid;
    logic m_cleared;

    function automatic string mnemonic(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   return "add";
                    6'h22:   return "sub";
                    6'h2A:   return "slt";
                    6'h08:   return "jr";
                    default: return "ill";
                endcase
            end
            6'h08:   return "addi";
            6'h0E:   return "xori";
            6'h23:   return "lw";
            6'h2B:   return "sw";
            6'h04:   return "beq";
            6'h05:   return "bne";
            6'h02:   return "j";
            6'h03:   return "jal";
            default: return "ill";
        endcase
    endfunction

    function automatic exp_t decodeRef(input logic [31:0] ins, input logic [31:0] p);
        exp_t  e;
        string m;
        e             = '{default: '0};
        m             = mnemonic(ins);
        e.rs          = ins[25:21];
        e.rt          = ins[20:16];
        e.shamt       = ins[10:6];
        e.pc_plus4    = p + 32'd4;
        e.jump_target = {e.pc_plus4[31:28], ins[25:0], 2'b00};
        e.imm_ext     = (m == "xori") ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        case (m)
            "add":  begin e.reg_write = 1; e.alu_control = 0; e.wr_addr = ins[15:11]; end
            "sub":  begin e.reg_write = 1; e.alu_control = 1; e.wr_addr = ins[15:11]; end
            "slt":  begin e.reg_write = 1; e.alu_control = 3; e.wr_addr = ins[15:11]; end
            "jr":   e.jump_reg = 1;
            "addi": begin e.alu_src = 1; e.reg_write = 1; e.wr_addr = ins[20:16]; end
            "xori": begin e.alu_src = 1; e.alu_control = 2; e.reg_write = 1; e.wr_addr = ins[20:16]; end
            "lw":   begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.wr_addr = ins[20:16]; end
            "sw":   begin e.alu_src = 1; e.mem_write = 1; end
            "beq":  begin e.alu_control = 1; e.branch_eq = 1; end
            "bne":  begin e.alu_control = 1; e.branch_ne = 1; end
            "j":    e.jump = 1;
            "jal":  begin e.jump = 1; e.jump_link = 1; e.reg_write = 1; e.wr_addr = 5'd31; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] randomInstr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 10))
            0:  r[31:26] = 6'h08;
            1:  r[31:26] = 6'h0E;
            2:  r[31:26] = 6'h23;
            3:  r[31:26] = 6'h2B;
            4:  r[31:26] = 6'h04;
            5:  r[31:26] = 6'h05;
            6:  r[31:26] = 6'h02;
            7:  r[31:26] = 6'h03;
            8, 9: begin
                r[31:26] = 6'h00;
                case ($urandom_range(0, 4))
                    0: r[5:0] = 6'h20;
                    1: r[5:0] = 6'h22;
                    2: r[5:0] = 6'h2A;
                    3: r[5:0] = 6'h08;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        compareValue("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid || m_cleared) begin
            compareValue("rs", 32'(bus.rs), 32'(m_word.rs));
            compareValue("rt", 32'(bus.rt), 32'(m_word.rt));
            if (m_word.reg_write)
                compareValue("wr_addr", 32'(bus.wr_addr), 32'(m_word.wr_addr));
            compareValue("shamt", 32'(bus.shamt), 32'(m_word.shamt));
            compareValue("imm_ext", bus.imm_ext, m_word.imm_ext);
            compareValue("jump_target", bus.jump_target, m_word.jump_target);
            compareValue("pc_plus4", bus.pc_plus4, m_word.pc_plus4);
            compareValue("ctrl", {bus.alu_src, bus.jump, bus.jump_link, bus.jump_reg, bus.branch_eq,
                                  bus.branch_ne, bus.mem_write, bus.mem_to_reg, bus.reg_write},
                         {m_word.alu_src, m_word.jump, m_word.jump_link, m_word.jump_reg,
                          m_word.branch_eq, m_word.branch_ne, m_word.mem_write,
                          m_word.mem_to_reg, m_word.reg_write});
            compareValue("alu_control", 32'(bus.alu_control), 32'(m_word.alu_control));
            compareValue("illegal", 32'(bus.illegal), 32'(m_word.illegal));
        end
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                 input logic rdy, input logic fl, input logic rst);
        logic xfer;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = p;
        bus.out_ready = rdy;
        bus.flush     = fl;
        reset         = rst;
        #1;
        compareValue("in_ready", 32'(bus.in_ready), 32'(!m_valid || rdy));
        xfer = v && (!m_valid || rdy);
        @(posedge clk);
        if (rst || fl) begin
            m_valid   = 1'b0;
            m_cleared = 1'b1;
            m_word    = '{default: '0};
        end else if (xfer) begin
            m_valid   = 1'b1;
            m_cleared = 1'b0;
            m_word    = decodeRef(ins, p);
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_valid   = 1'b0;
        m_cleared = 1'b0;
        m_word    = '{default: '0};

        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
        compareValue("reset_in_ready", 32'(bus.in_ready), 32'd1);
        compareValue("reset_imm", bus.imm_ext, 32'h0);

        applyStimulus(1, 32'h2129FFFF, 32'h00000100, 1, 0, 0);
        compareValue("addi_imm", bus.imm_ext, 32'hFFFFFFFF);
        compareValue("addi_wr", 32'(bus.wr_addr), 32'd9);
        compareValue("addi_alu_src", 32'(bus.alu_src), 32'd1);

        applyStimulus(1, 32'h8C880004, 32'h00000104, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'hAC880004, 32'h00000108, 0, 0, 0);
            compareValue("bp_lw_held", 32'(bus.mem_to_reg), 32'd1);
            compareValue("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        applyStimulus(1, 32'hAC880004, 32'h00000108, 1, 0, 0);
        compareValue("bp_sw_mem_write", 32'(bus.mem_write), 32'd1);
        compareValue("bp_sw_imm", bus.imm_ext, 32'd4);

        applyStimulus(1, 32'h0C100010, 32'h00400000, 1, 0, 0);
        compareValue("jal_target", bus.jump_target, 32'h00400040);
        compareValue("jal_wr", 32'(bus.wr_addr), 32'd31);
        compareValue("jal_pc4", bus.pc_plus4, 32'h00400004);

        applyStimulus(1, 32'h012A4020, 32'h00400004, 1, 1, 0);
        compareValue("flush_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1, 32'h012A4022, 32'h00400008, 1, 0, 0);
        compareValue("post_flush_sub", 32'(bus.alu_control), 32'd1);

        applyStimulus(1, 32'hFC000000, 32'h00000200, 1, 0, 0);
        compareValue("illegal_op", 32'(bus.illegal), 32'd1);
        applyStimulus(1, 32'h0000003F, 32'h00000204, 1, 0, 0);
        compareValue("illegal_funct", 32'(bus.illegal), 32'd1);

        applyStimulus(1, 32'h3929FFFF, 32'h00000300, 1, 0, 0);
        compareValue("xori_imm", bus.imm_ext, 32'h0000FFFF);
        applyStimulus(1, 32'h012A402A, 32'h00000304, 1, 0, 0);
        compareValue("slt_alu", 32'(bus.alu_control), 32'd3);
        applyStimulus(1, 32'h1529FFFE, 32'h00000308, 1, 0, 0);
        compareValue("bne_flag", 32'(bus.branch_ne), 32'd1);
        applyStimulus(1, 32'h03E00008, 32'h0000030C, 1, 0, 0);
        compareValue("jr_flag", 32'(bus.jump_reg), 32'd1);

        applyStimulus(1, 32'h2129FFFF, 32'hFFFFFFFC, 1, 0, 0);
        compareValue("pc_wrap", bus.pc_plus4, 32'h00000000);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        applyStimulus(1, 32'h8C880004, 32'h00000400, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
        compareValue("reset_mid_stall", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
            applyStimulus($urandom_range(0, 3) != 0, randomInstr(), p,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 63) == 0);
        end
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
